// File: rtl/status_register_unit.sv
//-----------------------------------------------------------------------------
// status_register_unit
//
// Architectural NZCV status register that sits beside the EXE stage.
//   * Captures ALU flags from flag-setting instructions whose condition passed.
//   * Saves the flags on exception entry and restores them on exception
//     return. Only one level of exception is supported.
//   * Tells the ID stage to stall when a conditional instruction depends on a
//     pending flag write. When the bypass is built in, it forwards the pending
//     value instead of stalling.
//
// Build option:
//   STATUS_FWD_EN  defined   -> statusFwd bypasses the pending write and
//                               statusHazard is tied low.
//                  undefined -> statusFwd = statusRegister and the ID stage
//                               stalls one cycle on a pending write.
//
// Parameters:
//   CNT_W           width of the saturating committed-flag-write counter
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-low reset
//   exeValid        EXE stage holds a real instruction
//   exeSBit         EXE instruction sets flags
//   exeCondState    EXE condition result (1 = execute)
//   aluStatus       new flags {z, c, n, v}
//   flush           kills the EXE instruction this cycle
//   idCondUsed      ID-stage instruction's condition is not AL
//   excEntry        exception entry pulse
//   excReturn       exception return pulse
//   statusRegister  registered flags {z, c, n, v}
//   statusFwd       flags presented to the ID-stage condition check
//   statusHazard    ID stage must stall one cycle
//   inException     FSM is in EXC
//   excError        one-cycle pulse, one cycle after an illegal exception event
//   flagWrites      saturating count of committed flag updates
//-----------------------------------------------------------------------------
module status_register_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exeValid,
    input  logic             exeSBit,
    input  logic             exeCondState,
    input  logic [3:0]       aluStatus,
    input  logic             flush,
    input  logic             idCondUsed,
    input  logic             excEntry,
    input  logic             excReturn,
    output logic [3:0]       statusRegister,
    output logic [3:0]       statusFwd,
    output logic             statusHazard,
    output logic             inException,
    output logic             excError,
    output logic [CNT_W-1:0] flagWrites
);

    typedef enum logic {
        NORMAL = 1'b0,
        EXC    = 1'b1
    } excState_t;

    excState_t  state;
    excState_t  stateNext;
    logic [3:0] savedStatus;
    logic [3:0] savedNext;
    logic [3:0] statusNext;
    logic       errNext;
    logic       commit;

    logic       upd;
    logic [3:0] nxt;
    logic       entryOnly;
    logic       returnOnly;

    // A flag write happens only for a live, flag-setting instruction whose
    // condition passed.
    assign upd = exeValid & exeSBit & exeCondState & ~flush;
    assign nxt = upd ? aluStatus : statusRegister;

    // If entry and return arrive together, both are illegal. Only the
    // isolated pulses can move the FSM.
    assign entryOnly  = excEntry & ~excReturn;
    assign returnOnly = excReturn & ~excEntry;

    //-------------------------------------------------------------------------
    // Next-state / next-value logic
    //-------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned. An unassigned path would infer a latch.
    always_comb begin
        stateNext  = state;
        statusNext = nxt;
        savedNext  = savedStatus;
        errNext    = 1'b0;
        commit     = upd;

        unique case (state)
            NORMAL: begin
                if (entryOnly) begin
                    // Save the flags after any same-cycle write, so the
                    // handler's return restores the post-instruction flags.
                    savedNext = nxt;
                    stateNext = EXC;
                end else if (excReturn) begin
                    // This covers a return with no open exception and a
                    // simultaneous entry+return. Any upd still commits.
                    errNext = 1'b1;
                end
            end
            EXC: begin
                if (returnOnly) begin
                    // The restore wins over a same-cycle write. That write is
                    // neither applied nor counted.
                    statusNext = savedStatus;
                    commit     = 1'b0;
                    stateNext  = NORMAL;
                end else if (excEntry) begin
                    // Nested entry, or entry+return together: flag the error
                    // and stay in EXC. Any upd still commits.
                    errNext = 1'b1;
                end
            end
            default: stateNext = NORMAL;
        endcase
    end

    //-------------------------------------------------------------------------
    // State registers
    //-------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register therefore samples the same pre-edge values, regardless of the
    // order of the statements.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= NORMAL;
            statusRegister <= 4'b0000;
            savedStatus    <= 4'b0000;
            excError       <= 1'b0;
            flagWrites     <= '0;
        end else begin
            state          <= stateNext;
            statusRegister <= statusNext;
            savedStatus    <= savedNext;
            excError       <= errNext;
            // The counter saturates at all-ones instead of wrapping.
            if (commit && (flagWrites != {CNT_W{1'b1}})) begin
                flagWrites <= flagWrites + CNT_W'(1);
            end
        end
    end

    assign inException = (state == EXC);

    //-------------------------------------------------------------------------
    // ID-stage view of the flags
    //-------------------------------------------------------------------------
`ifdef STATUS_FWD_EN
    // Bypass: present exactly what the register will hold after this edge.
    // That is the pending EXE write, or the saved copy when a return fires.
    // The conditional check then never has to wait.
    assign statusFwd    = statusNext;
    assign statusHazard = 1'b0;
`else
    // No bypass: a conditional instruction in ID that coincides with a
    // pending flag write stalls one cycle. It then reads the updated register.
    assign statusFwd    = statusRegister;
    assign statusHazard = upd & idCondUsed;
`endif

endmodule

// File: tb/tb_status_register_unit.sv
//-----------------------------------------------------------------------------
// Testbench for status_register_unit.
// Two instances share every input: dut (CNT_W = 8) and dutSat (CNT_W = 2).
// Expected values come from a cycle-level reference model written directly
// from the architectural rules.
//-----------------------------------------------------------------------------
module tb_status_register_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       exeValid, exeSBit, exeCondState, flush, idCondUsed;
    logic       excEntry, excReturn;
    logic [3:0] aluStatus;

    logic [3:0] statusRegister, statusFwd;
    logic       statusHazard, inException, excError;
    logic [7:0] flagWrites;

    logic [3:0] sStatusRegister, sStatusFwd;
    logic       sStatusHazard, sInException, sExcError;
    logic [1:0] sFlagWrites;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [3:0] mFlags, mSaved;
    bit         mInExc, mErr;
    int         mCnt, mCntSat;

    always #5 clk = ~clk;

    status_register_unit #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .exeValid(exeValid), .exeSBit(exeSBit),
        .exeCondState(exeCondState), .aluStatus(aluStatus), .flush(flush),
        .idCondUsed(idCondUsed), .excEntry(excEntry), .excReturn(excReturn),
        .statusRegister(statusRegister), .statusFwd(statusFwd),
        .statusHazard(statusHazard), .inException(inException),
        .excError(excError), .flagWrites(flagWrites)
    );

    status_register_unit #(.CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .exeValid(exeValid), .exeSBit(exeSBit),
        .exeCondState(exeCondState), .aluStatus(aluStatus), .flush(flush),
        .idCondUsed(idCondUsed), .excEntry(excEntry), .excReturn(excReturn),
        .statusRegister(sStatusRegister), .statusFwd(sStatusFwd),
        .statusHazard(sStatusHazard), .inException(sInException),
        .excError(sExcError), .flagWrites(sFlagWrites)
    );

    // ---------------- reference model ----------------
    function automatic bit modelUpd();
        return exeValid && exeSBit && exeCondState && !flush;
    endfunction

    function automatic logic [3:0] modelFwd();
`ifdef STATUS_FWD_EN
        if (mInExc && excReturn && !excEntry) return mSaved;
        return modelUpd() ? aluStatus : mFlags;
`else
        return mFlags;
`endif
    endfunction

    function automatic bit modelHaz();
`ifdef STATUS_FWD_EN
        return 1'b0;
`else
        return modelUpd() && idCondUsed;
`endif
    endfunction

    // One rising edge of architectural behaviour.
    task automatic modelEdge();
        bit u;
        bit apply;
        u = modelUpd();
        apply = u;
        mErr = 0;
        if (!rst) begin
            mFlags = 4'b0000; mSaved = 4'b0000; mInExc = 0; mCnt = 0; mCntSat = 0;
            return;
        end
        if (excEntry && excReturn) begin
            mErr = 1;
        end else if (excEntry) begin
            if (mInExc) mErr = 1;
            else begin
                mSaved = u ? aluStatus : mFlags;
                mInExc = 1;
            end
        end else if (excReturn) begin
            if (mInExc) begin
                apply = 0;
                mFlags = mSaved;
                mInExc = 0;
            end else mErr = 1;
        end
        if (apply) begin
            mFlags = aluStatus;
            if (mCnt < 255) mCnt++;
            if (mCntSat < 3) mCntSat++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic setIn(input bit v, input bit s, input bit c, input logic [3:0] alu,
                         input bit f, input bit idc, input bit en, input bit ret);
        exeValid = v; exeSBit = s; exeCondState = c; aluStatus = alu; flush = f;
        idCondUsed = idc; excEntry = en; excReturn = ret;
        #1;
    endtask

    task automatic idle();
        setIn(0, 0, 0, 4'h0, 0, 0, 0, 0);
    endtask

    // Inputs change on the falling edge. Outputs are sampled on the next
    // falling edge.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic doUpd(input logic [3:0] alu);
        setIn(1, 1, 1, alu, 0, 0, 0, 0);
        tick();
    endtask

    task automatic checkModel(input string tag);
        tests++;
        if (statusRegister !== mFlags || inException !== mInExc || excError !== mErr ||
            flagWrites !== 8'(mCnt) || sFlagWrites !== 2'(mCntSat)) begin
            fails++;
            $display("FAIL %s: sr=%b inExc=%b err=%b cnt=%0d sat=%0d, expected sr=%b inExc=%b err=%b cnt=%0d sat=%0d",
                     tag, statusRegister, inException, excError, flagWrites, sFlagWrites,
                     mFlags, mInExc, mErr, mCnt, mCntSat);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0;
        setIn(1, 1, 1, 4'b1111, 0, 1, 1, 0);
        tick();
        tick();
        tests++;
        if (statusRegister !== 4'b0000 || inException !== 1'b0 || excError !== 1'b0 ||
            flagWrites !== 8'd0 || sFlagWrites !== 2'd0) begin
            fails++;
            $display("FAIL reset: sr=%b inExc=%b err=%b cnt=%0d sat=%0d, expected all zero",
                     statusRegister, inException, excError, flagWrites, sFlagWrites);
        end
        rst = 1;
        doUpd(4'b1010);
        tests++;
        if (statusRegister !== 4'b1010 || flagWrites !== 8'd1) begin
            fails++;
            $display("FAIL first_update: sr=%b cnt=%0d, expected sr=1010 cnt=1",
                     statusRegister, flagWrites);
        end
    endtask

    task automatic test_suppressed();
        setIn(1, 1, 0, 4'b1111, 0, 0, 0, 0);
        tick();
        tests++;
        if (statusRegister !== 4'b1010 || flagWrites !== 8'd1) begin
            fails++;
            $display("FAIL cond_fail: sr=%b cnt=%0d, expected sr=1010 cnt=1", statusRegister, flagWrites);
        end
        setIn(1, 1, 1, 4'b1111, 1, 0, 0, 0);
        tick();
        tests++;
        if (statusRegister !== 4'b1010 || flagWrites !== 8'd1) begin
            fails++;
            $display("FAIL flushed: sr=%b cnt=%0d, expected sr=1010 cnt=1", statusRegister, flagWrites);
        end
    endtask

    task automatic test_exception_round_trip();
        int c0;
        int excCycles;
        logic [3:0] exp [3];
        exp[0] = 4'b1000; exp[1] = 4'b0011; exp[2] = 4'b1000;
        doUpd(4'b0100);
        c0 = int'(flagWrites);
        excCycles = 0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: setIn(1, 1, 1, 4'b1000, 0, 0, 1, 0);
                1: setIn(1, 1, 1, 4'b0011, 0, 0, 0, 0);
                default: setIn(1, 1, 1, 4'b1111, 0, 0, 0, 1);
            endcase
            tick();
            if (inException) excCycles++;
            tests++;
            if (statusRegister !== exp[i]) begin
                fails++;
                $display("FAIL round_trip_step%0d: sr=%b, expected %b", i, statusRegister, exp[i]);
            end
        end
        idle();
        tick();
        if (inException) excCycles++;
        tests++;
        if (excCycles != 2 || int'(flagWrites) != c0 + 2) begin
            fails++;
            $display("FAIL round_trip_summary: excCycles=%0d cntDelta=%0d, expected 2 and 2",
                     excCycles, int'(flagWrites) - c0);
        end
    endtask

    task automatic test_illegal();
        // Enter first, then a nested entry while in EXC.
        setIn(0, 0, 0, 4'h0, 0, 0, 1, 0); tick();
        setIn(1, 1, 1, 4'b0110, 0, 0, 1, 0); tick();
        tests++;
        if (excError !== 1'b1 || inException !== 1'b1 || statusRegister !== 4'b0110) begin
            fails++;
            $display("FAIL nested_entry: err=%b inExc=%b sr=%b, expected 1 1 0110",
                     excError, inException, statusRegister);
        end
        // Both together while in EXC: upd applies, state unchanged.
        setIn(1, 1, 1, 4'b0101, 0, 0, 1, 1); tick();
        tests++;
        if (excError !== 1'b1 || inException !== 1'b1 || statusRegister !== 4'b0101) begin
            fails++;
            $display("FAIL both_in_exc: err=%b inExc=%b sr=%b, expected 1 1 0101",
                     excError, inException, statusRegister);
        end
        idle(); tick();
        tests++;
        if (excError !== 1'b0) begin
            fails++;
            $display("FAIL err_single_cycle: err=%b, expected 0", excError);
        end
        // Legal return, then a return while in NORMAL.
        setIn(0, 0, 0, 4'h0, 0, 0, 0, 1); tick();
        checkModel("legal_return");
        setIn(0, 0, 0, 4'h0, 0, 0, 0, 1); tick();
        tests++;
        if (excError !== 1'b1 || inException !== 1'b0) begin
            fails++;
            $display("FAIL stray_return: err=%b inExc=%b, expected 1 0", excError, inException);
        end
        // Both together in NORMAL.
        setIn(1, 1, 1, 4'b0010, 0, 0, 1, 1); tick();
        tests++;
        if (excError !== 1'b1 || inException !== 1'b0 || statusRegister !== 4'b0010) begin
            fails++;
            $display("FAIL both_in_normal: err=%b inExc=%b sr=%b, expected 1 0 0010",
                     excError, inException, statusRegister);
        end
        idle(); tick();
        checkModel("after_illegal");
    endtask

    task automatic test_hazard();
        logic [3:0] old;
        old = statusRegister;
        setIn(1, 1, 1, 4'b0001, 0, 1, 0, 0);
        tests++;
`ifdef STATUS_FWD_EN
        if (statusHazard !== 1'b0 || statusFwd !== 4'b0001) begin
            fails++;
            $display("FAIL hazard_fwd: haz=%b fwd=%b, expected 0 0001", statusHazard, statusFwd);
        end
`else
        if (statusHazard !== 1'b1 || statusFwd !== old) begin
            fails++;
            $display("FAIL hazard_stall: haz=%b fwd=%b, expected 1 %b", statusHazard, statusFwd, old);
        end
`endif
        tick();
        idle();
        tests++;
        if (statusHazard !== 1'b0 || statusFwd !== 4'b0001) begin
            fails++;
            $display("FAIL hazard_after: haz=%b fwd=%b, expected 0 0001", statusHazard, statusFwd);
        end
    endtask

    task automatic test_saturation();
        int exp [5];
        exp = '{1, 2, 3, 3, 3};
        rst = 0; idle(); tick();
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            doUpd(4'(i));
            tests++;
            if (int'(sFlagWrites) != exp[i]) begin
                fails++;
                $display("FAIL saturation_%0d: cnt=%0d, expected %0d", i, sFlagWrites, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            setIn(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  4'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            tests++;
            if (statusHazard !== modelHaz() || statusFwd !== modelFwd()) begin
                fails++;
                $display("FAIL random_comb_%0d: haz=%b fwd=%b, expected %b %b",
                         i, statusHazard, statusFwd, modelHaz(), modelFwd());
            end
            tick();
            checkModel($sformatf("random_%0d", i));
        end
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_suppressed();
        test_exception_round_trip();
        test_illegal();
        test_hazard();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
